uart_keypad: RTL

Host-side keypad bridge for the Simon Says board top. It consumes bytes arriving on the board UART receive interface (`rxdata`/`rxready`/`rxclk`) and decodes printable keys into timed one-hot push-button pulses. The top ORs these pulses into the game's `pb[19:0]` input. Each accepted byte is echoed back on the UART transmit interface (`txdata`/`txready`/`txclk`), so a terminal can play the game without the physical buttons.

---
 rtl/uart_keypad_if.sv | 20 ++
 rtl/uart_keypad.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_keypad_if.sv
// UART byte-stream handshake between the board UART and the keypad bridge.
// The master side is the UART; the slave side is the keypad bridge.
interface uart_keypad_if;
   logic [7:0] rxdata;
   logic       rxready;
   logic       rxclk;
   logic [7:0] txdata;
   logic       txready;
   logic       txclk;

   modport master (
      output rxdata, rxready, txready,
      input  rxclk, txdata, txclk
   );

   modport slave (
      input  rxdata, rxready, txready,
      output rxclk, txdata, txclk
   );
endinterface

// File: rtl/uart_keypad.sv
// Turns received UART bytes into timed one-hot button pulses.
// Each byte is echoed back, or '?' if it does not decode.
module uart_keypad #(
   parameter logic [7:0] PULSE_LEN = 8'd2,
   parameter bit         ECHO      = 1'b1
) (
   input  logic          hz100,
   input  logic          reset,
   uart_keypad_if.slave  uif,
   output logic [19:0]   pb_out,
   output logic [3:0]    errcnt
);

   // A zero pulse length still gives a one-cycle press.
   localparam logic [7:0] CNT_INIT = (PULSE_LEN == 8'd0) ? 8'd0 : PULSE_LEN - 8'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK,
      S_PRESS,
      S_ECHO_WAIT,
      S_ECHO,
      S_GAP
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  byte_q, byte_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rxclk_q, rxclk_d;
   logic        txclk_q, txclk_d;
   logic [7:0]  txdata_q, txdata_d;
   logic [19:0] pb_q, pb_d;
   logic [3:0]  err_q, err_d;

   logic        key_vld;
   logic [4:0]  key_idx;
   logic [19:0] key_onehot;
   logic [7:0]  echo_byte;

   always_comb begin
      key_vld = 1'b1;
      key_idx = 5'd0;
      if (byte_q inside {[8'h30:8'h39]})
         key_idx = 5'(byte_q - 8'h30);
      else if (byte_q inside {[8'h41:8'h46]})
         key_idx = 5'(byte_q - 8'h41) + 5'd10;
      else if (byte_q inside {[8'h61:8'h66]})
         key_idx = 5'(byte_q - 8'h61) + 5'd10;
      else if (byte_q inside {[8'h57:8'h5A]})
         key_idx = 5'(byte_q - 8'h57) + 5'd16;
      else if (byte_q inside {[8'h77:8'h7A]})
         key_idx = 5'(byte_q - 8'h77) + 5'd16;
      else
         key_vld = 1'b0;
      key_onehot = 20'd1 << key_idx;
      echo_byte  = key_vld ? byte_q : 8'h3F;
   end

   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      cnt_d    = cnt_q;
      rxclk_d  = 1'b0;
      txclk_d  = 1'b0;
      txdata_d = txdata_q;
      pb_d     = pb_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (uif.rxready) begin
               byte_d  = uif.rxdata;
               rxclk_d = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (key_vld) begin
               pb_d    = key_onehot;
               cnt_d   = CNT_INIT;
               state_d = S_PRESS;
            end else begin
               err_d   = (err_q == 4'hF) ? err_q : err_q + 4'd1;
               state_d = ECHO ? S_ECHO_WAIT : S_GAP;
            end
         end
         S_PRESS: begin
            if (cnt_q == 8'd0) begin
               pb_d    = '0;
               state_d = ECHO ? S_ECHO_WAIT : S_GAP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_ECHO_WAIT: begin
            if (uif.txready) begin
               txdata_d = echo_byte;
               txclk_d  = 1'b1;
               state_d  = S_ECHO;
            end
         end
         S_ECHO:  state_d = S_GAP;
         // One idle cycle guarantees a release edge between repeated keys.
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         byte_q   <= 8'h00;
         cnt_q    <= 8'h00;
         rxclk_q  <= 1'b0;
         txclk_q  <= 1'b0;
         txdata_q <= 8'h00;
         pb_q     <= '0;
         err_q    <= 4'h0;
      end else begin
         state_q  <= state_d;
         byte_q   <= byte_d;
         cnt_q    <= cnt_d;
         rxclk_q  <= rxclk_d;
         txclk_q  <= txclk_d;
         txdata_q <= txdata_d;
         pb_q     <= pb_d;
         err_q    <= err_d;
      end
   end

   assign uif.rxclk  = rxclk_q;
   assign uif.txclk  = txclk_q;
   assign uif.txdata = txdata_q;
   assign pb_out     = pb_q;
   assign errcnt     = err_q;

endmodule
